spi_byte_link: RTL and testbench

- Single-clock SPI-style byte link with two halves sharing CLK and CLR.
- Sender: parallel-load 8-bit transmit shift register, serialised MSB-first onto MOSI.
- Receiver: deserialises MISO into an 8-bit shift register and presents the byte on DATA_OUT when read.
- Used as the serial endpoint pair in a loopback or point-to-point link; the clock is generated externally.

---
 rtl/spi_byte_link.sv | 119 +++++++++++
 tb/tb_spi_byte_link.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_byte_link.sv
// SPI-style byte link: MSB-first parallel-to-serial sender and serial-to-parallel receiver.
// Define SPI_BYTE_LINK_OVERRUN_EN to add the sticky R_OVERRUN output.
module spi_byte_link #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  CLR,
  input  logic [DATA_WIDTH-1:0] DATA_IN,
  input  logic                  WRITE,
  input  logic                  TE,
  output logic                  MOSI,
  output logic                  S_FULL_STATE,
  output logic                  S_EMPTY_STATE,
  input  logic                  MISO,
  input  logic                  RE,
  input  logic                  READ,
  output logic [DATA_WIDTH-1:0] DATA_OUT,
  output logic                  R_FULL_STATE,
  output logic                  R_EMPTY_STATE
`ifdef SPI_BYTE_LINK_OVERRUN_EN
  ,
  output logic                  R_OVERRUN
`endif
);

  localparam int unsigned CW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DATA_WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [DATA_WIDTH-1:0] tx_sreg_q, tx_sreg_d;
  logic [CW-1:0]         tx_cnt_q, tx_cnt_d;
  logic [DATA_WIDTH-1:0] rx_sreg_q, rx_sreg_d;
  logic [CW-1:0]         rx_cnt_q, rx_cnt_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;

  logic s_full, s_empty, r_full, r_empty;
  logic write_ok, read_ok;

  assign s_full   = (tx_cnt_q == CNT_FULL);
  assign s_empty  = (tx_cnt_q == '0);
  assign r_full   = (rx_cnt_q == CNT_FULL);
  assign r_empty  = (rx_cnt_q == '0);
  assign write_ok = WRITE && (s_full || s_empty);
  assign read_ok  = READ && r_full;

  assign MOSI          = (TE && !s_empty) ? tx_sreg_q[DATA_WIDTH-1] : 1'b0;
  assign S_FULL_STATE  = s_full;
  assign S_EMPTY_STATE = s_empty;
  assign R_FULL_STATE  = r_full;
  assign R_EMPTY_STATE = r_empty;
  assign DATA_OUT      = dout_q;

  // A load wins over a shift in the same cycle; a load mid-transfer is dropped.
  always_comb begin
    tx_sreg_d = tx_sreg_q;
    tx_cnt_d  = tx_cnt_q;
    if (write_ok) begin
      tx_sreg_d = DATA_IN;
      tx_cnt_d  = CNT_FULL;
    end else if (TE && !s_empty) begin
      tx_sreg_d = {tx_sreg_q[DATA_WIDTH-2:0], 1'b0};
      tx_cnt_d  = tx_cnt_q - CNT_ONE;
    end
  end

  // A successful read frees the receiver and suppresses sampling that cycle.
  always_comb begin
    rx_sreg_d = rx_sreg_q;
    rx_cnt_d  = rx_cnt_q;
    dout_d    = dout_q;
    if (read_ok) begin
      dout_d   = rx_sreg_q;
      rx_cnt_d = '0;
    end else if (RE && !r_full) begin
      rx_sreg_d = {rx_sreg_q[DATA_WIDTH-2:0], MISO};
      rx_cnt_d  = rx_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      tx_sreg_q <= '0;
      tx_cnt_q  <= '0;
      rx_sreg_q <= '0;
      rx_cnt_q  <= '0;
      dout_q    <= '0;
    end else begin
      tx_sreg_q <= tx_sreg_d;
      tx_cnt_q  <= tx_cnt_d;
      rx_sreg_q <= rx_sreg_d;
      rx_cnt_q  <= rx_cnt_d;
      dout_q    <= dout_d;
    end
  end

`ifdef SPI_BYTE_LINK_OVERRUN_EN
  logic ovr_q, ovr_d;

  always_comb begin
    ovr_d = ovr_q;
    if (read_ok) begin
      ovr_d = 1'b0;
    end else if (RE && r_full) begin
      ovr_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      ovr_q <= 1'b0;
    end else begin
      ovr_q <= ovr_d;
    end
  end

  assign R_OVERRUN = ovr_q;
`endif

endmodule

// File: tb/tb_spi_byte_link.sv
// Self-checking bench for spi_byte_link: directed scenarios plus random traffic
// checked against a bit-queue reference model.
module tb_spi_byte_link;

  localparam int unsigned W = 8;

  logic         CLK = 1'b0;
  logic         CLR, WRITE, TE, RE, READ, MISO_r, loop;
  logic [W-1:0] DATA_IN;
  logic         MISO, MOSI, S_FULL_STATE, S_EMPTY_STATE, R_FULL_STATE, R_EMPTY_STATE;
  logic [W-1:0] DATA_OUT;
`ifdef SPI_BYTE_LINK_OVERRUN_EN
  logic         R_OVERRUN;
`endif

  assign MISO = loop ? MOSI : MISO_r;

  spi_byte_link #(.DATA_WIDTH(W)) dut (
    .CLK(CLK), .CLR(CLR), .DATA_IN(DATA_IN), .WRITE(WRITE), .TE(TE), .MOSI(MOSI),
    .S_FULL_STATE(S_FULL_STATE), .S_EMPTY_STATE(S_EMPTY_STATE), .MISO(MISO), .RE(RE),
    .READ(READ), .DATA_OUT(DATA_OUT), .R_FULL_STATE(R_FULL_STATE),
    .R_EMPTY_STATE(R_EMPTY_STATE)
`ifdef SPI_BYTE_LINK_OVERRUN_EN
    , .R_OVERRUN(R_OVERRUN)
`endif
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Reference model: sender is a queue of unsent bits, receiver a queue of received bits.
  bit           txq[$];
  bit           rxq[$];
  logic [W-1:0] m_dout;
  bit           m_ovr;
  logic         mosi_seen, mosi_exp;

  function automatic void model_reset();
    txq.delete();
    rxq.delete();
    m_dout = '0;
    m_ovr  = 1'b0;
  endfunction

  // Drive one clock cycle; MOSI is captured before the edge, the model advances with the edge.
  task automatic tick(input logic wr, input logic [W-1:0] din, input logic te,
                      input logic re, input logic rd);
    logic         miso_m;
    logic [W-1:0] packed_byte;
    int unsigned  tx_n;
    WRITE = wr; DATA_IN = din; TE = te; RE = re; READ = rd;
    @(negedge CLK);
    tx_n      = txq.size();
    mosi_exp  = (te && tx_n > 0) ? txq[0] : 1'b0;
    mosi_seen = MOSI;
    miso_m    = loop ? mosi_exp : MISO_r;
    if (CLR) begin
      model_reset();
    end else begin
      if (wr && (tx_n == W || tx_n == 0)) begin
        txq.delete();
        for (int i = W - 1; i >= 0; i--) txq.push_back(din[i]);
      end else if (te && tx_n > 0) begin
        void'(txq.pop_front());
      end
      if (rd && rxq.size() == W) begin
        for (int i = 0; i < int'(W); i++) packed_byte[W-1-i] = rxq[i];
        m_dout = packed_byte;
        rxq.delete();
        m_ovr = 1'b0;
      end else if (re && rxq.size() < W) begin
        rxq.push_back(miso_m);
      end else if (re && rxq.size() == W) begin
        m_ovr = 1'b1;
      end
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    WRITE = 0; TE = 0; RE = 0; READ = 0; DATA_IN = '0; MISO_r = 0;
  endtask

  task automatic do_clear();
    CLR = 1'b1;
    #1;
    model_reset();
    @(posedge CLK);
    #1;
    CLR = 1'b0;
  endtask

  task automatic test_reset();
    loop = 1'b1;
    tick(1, 8'hFF, 0, 0, 0);
    tick(0, '0, 1, 1, 0);
    tick(0, '0, 1, 1, 0);
    tick(0, '0, 1, 1, 0);
    TE = 1'b1;
    #2;
    CLR = 1'b1;
    #1;
    model_reset();
    checks++;
    if (S_EMPTY_STATE !== 1'b1 || S_FULL_STATE !== 1'b0) begin
      errors++; $display("FAIL reset_sender: full=%b empty=%b expected full=0 empty=1", S_FULL_STATE, S_EMPTY_STATE);
    end
    checks++;
    if (R_EMPTY_STATE !== 1'b1 || R_FULL_STATE !== 1'b0) begin
      errors++; $display("FAIL reset_receiver: full=%b empty=%b expected full=0 empty=1", R_FULL_STATE, R_EMPTY_STATE);
    end
    checks++;
    if (MOSI !== 1'b0 || DATA_OUT !== 8'h00) begin
      errors++; $display("FAIL reset_outputs: MOSI=%b DATA_OUT=%h expected 0/00", MOSI, DATA_OUT);
    end
    // CLR held across an edge must dominate a WRITE.
    tick(1, 8'h5A, 1, 1, 0);
    checks++;
    if (S_EMPTY_STATE !== 1'b1) begin
      errors++; $display("FAIL reset_dominates: S_EMPTY=%b expected 1", S_EMPTY_STATE);
    end
    CLR = 1'b0;
    idle_inputs();
  endtask

  task automatic test_load();
    tick(1, 8'h62, 0, 0, 0);
    checks++;
    if (S_FULL_STATE !== 1'b1 || S_EMPTY_STATE !== 1'b0) begin
      errors++; $display("FAIL load_flags: full=%b empty=%b expected full=1 empty=0", S_FULL_STATE, S_EMPTY_STATE);
    end
    for (int i = 0; i < 4; i++) begin
      tick(0, '0, 0, 0, 0);
      checks++;
      if (mosi_seen !== 1'b0 || S_FULL_STATE !== 1'b1) begin
        errors++; $display("FAIL load_idle%0d: MOSI=%b full=%b expected 0/1", i, mosi_seen, S_FULL_STATE);
      end
    end
  endtask

  task automatic test_loopback();
    logic [W-1:0] pat;
    loop = 1'b1;
    pat = 8'h62;
    for (int i = 0; i < 11; i++) begin
      tick(0, '0, 1, 1, 0);
      checks++;
      if (mosi_seen !== ((i < 8) ? pat[7-i] : 1'b0)) begin
        errors++; $display("FAIL loop_mosi%0d: got %b expected %b", i, mosi_seen, (i < 8) ? pat[7-i] : 1'b0);
      end
      if (i == 7 || i == 10) begin
        checks++;
        if (S_EMPTY_STATE !== 1'b1 || R_FULL_STATE !== 1'b1) begin
          errors++; $display("FAIL loop_done%0d: S_EMPTY=%b R_FULL=%b expected 1/1", i, S_EMPTY_STATE, R_FULL_STATE);
        end
      end
    end
`ifdef SPI_BYTE_LINK_OVERRUN_EN
    checks++;
    if (R_OVERRUN !== 1'b1) begin
      errors++; $display("FAIL loop_overrun: got %b expected 1", R_OVERRUN);
    end
`endif
  endtask

  task automatic test_read();
    tick(0, '0, 0, 0, 1);
    checks++;
    if (DATA_OUT !== 8'h62 || R_EMPTY_STATE !== 1'b1) begin
      errors++; $display("FAIL read_first: DATA_OUT=%h R_EMPTY=%b expected 62/1", DATA_OUT, R_EMPTY_STATE);
    end
`ifdef SPI_BYTE_LINK_OVERRUN_EN
    checks++;
    if (R_OVERRUN !== 1'b0) begin
      errors++; $display("FAIL read_overrun_clr: got %b expected 0", R_OVERRUN);
    end
`endif
    tick(0, '0, 0, 0, 1);
    checks++;
    if (DATA_OUT !== 8'h62 || R_EMPTY_STATE !== 1'b1) begin
      errors++; $display("FAIL read_second: DATA_OUT=%h R_EMPTY=%b expected 62/1", DATA_OUT, R_EMPTY_STATE);
    end
  endtask

  task automatic test_send_no_receive();
    do_clear();
    loop = 1'b1;
    tick(1, 8'h62, 0, 0, 0);
    for (int i = 0; i < 11; i++) tick(0, '0, 1, 0, 0);
    checks++;
    if (S_EMPTY_STATE !== 1'b1 || R_EMPTY_STATE !== 1'b1) begin
      errors++; $display("FAIL noreceive_flags: S_EMPTY=%b R_EMPTY=%b expected 1/1", S_EMPTY_STATE, R_EMPTY_STATE);
    end
    tick(0, '0, 0, 0, 1);
    checks++;
    if (DATA_OUT !== 8'h00) begin
      errors++; $display("FAIL noreceive_read: DATA_OUT=%h expected 00", DATA_OUT);
    end
  endtask

  task automatic test_priority();
    loop = 1'b1;
    tick(1, 8'h3C, 0, 0, 0);
    for (int i = 0; i < 3; i++) tick(0, '0, 1, 1, 0);
    tick(1, 8'hA5, 1, 1, 0);
    checks++;
    if (S_FULL_STATE !== 1'b0 || S_EMPTY_STATE !== 1'b0) begin
      errors++; $display("FAIL prio_ignored: full=%b empty=%b expected 0/0", S_FULL_STATE, S_EMPTY_STATE);
    end
    for (int i = 0; i < 4; i++) tick(0, '0, 1, 1, 0);
    tick(0, '0, 0, 0, 1);
    checks++;
    if (DATA_OUT !== 8'h3C || S_EMPTY_STATE !== 1'b1) begin
      errors++; $display("FAIL prio_complete: DATA_OUT=%h S_EMPTY=%b expected 3c/1", DATA_OUT, S_EMPTY_STATE);
    end
    // Reload while full with TE high: load wins, nothing shifts.
    tick(1, 8'h81, 0, 0, 0);
    tick(1, 8'h7E, 1, 0, 0);
    checks++;
    if (S_FULL_STATE !== 1'b1) begin
      errors++; $display("FAIL prio_reload_full: full=%b expected 1", S_FULL_STATE);
    end
    tick(0, '0, 1, 0, 0);
    checks++;
    if (mosi_seen !== 1'b0) begin
      errors++; $display("FAIL prio_reload_msb: MOSI=%b expected 0 (msb of 7e)", mosi_seen);
    end
  endtask

  task automatic test_random();
    do_clear();
    for (int n = 0; n < 400; n++) begin
      loop   = ($urandom_range(0, 3) != 0);
      MISO_r = 1'($urandom_range(0, 1));
      tick(($urandom_range(0, 5) == 0), 8'($urandom), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0));
      checks++;
      if (mosi_seen !== mosi_exp) begin
        errors++; $display("FAIL rand_mosi[%0d]: got %b expected %b", n, mosi_seen, mosi_exp);
      end
      checks++;
      if (S_FULL_STATE !== (txq.size() == W) || S_EMPTY_STATE !== (txq.size() == 0)) begin
        errors++; $display("FAIL rand_sender[%0d]: full=%b empty=%b expected unsent=%0d", n, S_FULL_STATE, S_EMPTY_STATE, txq.size());
      end
      checks++;
      if (R_FULL_STATE !== (rxq.size() == W) || R_EMPTY_STATE !== (rxq.size() == 0)) begin
        errors++; $display("FAIL rand_receiver[%0d]: full=%b empty=%b expected held=%0d", n, R_FULL_STATE, R_EMPTY_STATE, rxq.size());
      end
      checks++;
      if (DATA_OUT !== m_dout) begin
        errors++; $display("FAIL rand_data_out[%0d]: got %h expected %h", n, DATA_OUT, m_dout);
      end
`ifdef SPI_BYTE_LINK_OVERRUN_EN
      checks++;
      if (R_OVERRUN !== m_ovr) begin
        errors++; $display("FAIL rand_overrun[%0d]: got %b expected %b", n, R_OVERRUN, m_ovr);
      end
`endif
    end
  endtask

  initial begin
    loop = 1'b0;
    idle_inputs();
    CLR = 1'b1;
    model_reset();
    #12;
    CLR = 1'b0;
    @(posedge CLK);
    #1;
    test_reset();
    test_load();
    test_loopback();
    test_read();
    test_send_no_receive();
    test_priority();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
